// File: rtl/clk_step_ctrl.sv
// CPU clock-enable generator: halt, divided free-run, debounced single-step and N-step burst.
// Latency: 2-flop sync + DEB_CYCLES debounce; cpu_ce issues the cycle after a press or divider terminal count.
// No backpressure: cpu_ce is a one-cycle enable that the CPU must accept whenever it is high.
module clk_step_ctrl #(
  parameter int DIV        = 25_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BURST_W    = 8,
  parameter int CNT_W      = 16
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               button,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               step_clr,
  output logic               cpu_ce,
  output logic               busy,
  output logic               btn_db,
  output logic [CNT_W-1:0]   step_cnt
);

  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [1:0]         mode_s1;
  logic [1:0]         m_s;
  logic [1:0]         m_prev;
  logic               b_s1;
  logic               b_s;
  logic [DEB_W-1:0]   deb_cnt;
  logic               btn_db_q;
  logic               press;
  logic               mode_chg;
  logic [DIV_W-1:0]   div_cnt;
  logic [BURST_W-1:0] remaining;
  state_t             state;

  // Two-flop synchronisers for the switch and button inputs, plus the previous mode for edge detection
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      mode_s1 <= '0;
      m_s     <= '0;
      m_prev  <= '0;
      b_s1    <= 1'b0;
      b_s     <= 1'b0;
    end else begin
      mode_s1 <= mode;
      m_s     <= mode_s1;
      m_prev  <= m_s;
      b_s1    <= button;
      b_s     <= b_s1;
    end
  end

  // Debounce: the level only changes after DEB_CYCLES consecutive cycles of disagreement
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (b_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_db  <= b_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign press    = btn_db & ~btn_db_q;
  assign mode_chg = (m_s != m_prev);

  // Mode FSM, divider and burst counter; cpu_ce and busy are registered here
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      div_cnt   <= '0;
      cpu_ce    <= 1'b0;
      busy      <= 1'b0;
    end else if (mode_chg) begin
      // The change cycle itself counts as divider count 0, so RUN's first pulse lands DIV cycles later
      state     <= S_IDLE;
      remaining <= '0;
      div_cnt   <= (m_s == MODE_RUN) ? DIV_W'(1) : '0;
      cpu_ce    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (m_s)
        MODE_HALT: begin
          div_cnt <= '0;
          cpu_ce  <= 1'b0;
        end
        MODE_RUN: begin
          if (div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
            cpu_ce  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            cpu_ce  <= 1'b0;
          end
        end
        MODE_STEP: begin
          div_cnt <= '0;
          cpu_ce  <= press;
        end
        MODE_BURST: begin
          div_cnt <= '0;
          case (state)
            S_IDLE: begin
              if (press && (burst_len != '0)) begin
                state     <= S_BURST;
                remaining <= burst_len;
                busy      <= 1'b1;
                cpu_ce    <= 1'b1;
              end else begin
                cpu_ce <= 1'b0;
              end
            end
            S_BURST: begin
              // remaining counts the pulse currently on cpu_ce; presses here are ignored
              if (remaining == BURST_W'(1)) begin
                state     <= S_IDLE;
                remaining <= '0;
                busy      <= 1'b0;
                cpu_ce    <= 1'b0;
              end else begin
                remaining <= remaining - BURST_W'(1);
                cpu_ce    <= 1'b1;
              end
            end
            default: begin
              state  <= S_IDLE;
              busy   <= 1'b0;
              cpu_ce <= 1'b0;
            end
          endcase
        end
        default: begin
          cpu_ce <= 1'b0;
        end
      endcase
    end
  end

  // Step counter: clear wins over the increment from a concurrent pulse
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
    end else if (step_clr) begin
      step_cnt <= '0;
    end else if (cpu_ce) begin
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

endmodule
